// File: rtl/jpeg_stream_sequencer.sv
// JPEG frame output sequencer: SOI, header segments (DQT/SOF0/DHT/SOS), byte-stuffed scan data, EOI.
// The output is a single registered byte stage with valid/ready. Scan-side ready is combinational from m_ready.
module jpeg_stream_sequencer #(
  parameter int DQT_BYTES = 134,
  parameter int SOF_BYTES = 19,
  parameter int DHT_BYTES = 420,
  parameter int SOS_BYTES = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DQT_BYTES-1:0][7:0] dqt_array,
  input  logic [SOF_BYTES-1:0][7:0] sof_array,
  input  logic [DHT_BYTES-1:0][7:0] dht_array,
  input  logic [SOS_BYTES-1:0][7:0] sos_array,
  input  logic [7:0]                s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [7:0]                m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int MAX_AB = (DQT_BYTES > SOF_BYTES) ? DQT_BYTES : SOF_BYTES;
  localparam int MAX_CD = (DHT_BYTES > SOS_BYTES) ? DHT_BYTES : SOS_BYTES;
  localparam int MAX_N  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_N) + 1;
  localparam int DQT_IW = (DQT_BYTES > 1) ? $clog2(DQT_BYTES) : 1;
  localparam int SOF_IW = (SOF_BYTES > 1) ? $clog2(SOF_BYTES) : 1;
  localparam int DHT_IW = (DHT_BYTES > 1) ? $clog2(DHT_BYTES) : 1;
  localparam int SOS_IW = (SOS_BYTES > 1) ? $clog2(SOS_BYTES) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOI,
    S_DQT,
    S_SOF,
    S_DHT,
    S_SOS,
    S_SCAN,
    S_STUFF,
    S_EOI
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pend_last, w_pend_nxt;
  logic [7:0]       r_m_data;
  logic             r_m_valid, r_m_last, r_done;

  logic             w_adv;
  logic             w_out_valid, w_out_last, w_done_nxt;
  logic [7:0]       w_out_data;
  logic [DQT_IW-1:0] w_dqt_idx;
  logic [SOF_IW-1:0] w_sof_idx;
  logic [DHT_IW-1:0] w_dht_idx;
  logic [SOS_IW-1:0] w_sos_idx;

  // The output stage may take a new byte when it is empty or its byte leaves this cycle.
  assign w_adv   = !r_m_valid || m_ready;
  assign s_ready = (r_state == S_SCAN) && w_adv;

  // Segment byte k is stored at array index N-1-k.
  assign w_dqt_idx = DQT_IW'(DQT_BYTES - 1 - int'(r_cnt));
  assign w_sof_idx = SOF_IW'(SOF_BYTES - 1 - int'(r_cnt));
  assign w_dht_idx = DHT_IW'(DHT_BYTES - 1 - int'(r_cnt));
  assign w_sos_idx = SOS_IW'(SOS_BYTES - 1 - int'(r_cnt));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend_last;
    w_out_valid = 1'b0;
    w_out_data  = 8'h00;
    w_out_last  = 1'b0;
    w_done_nxt  = 1'b0;

    if (w_adv) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_out_valid = 1'b1;
            w_out_data  = 8'hFF;
            w_state_nxt = S_SOI;
          end
        end
        S_SOI: begin
          w_out_valid = 1'b1;
          w_out_data  = 8'hD8;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DQT;
        end
        S_DQT: begin
          w_out_valid = 1'b1;
          w_out_data  = dqt_array[w_dqt_idx];
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DQT_BYTES - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SOF;
          end
        end
        S_SOF: begin
          w_out_valid = 1'b1;
          w_out_data  = sof_array[w_sof_idx];
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(SOF_BYTES - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DHT;
          end
        end
        S_DHT: begin
          w_out_valid = 1'b1;
          w_out_data  = dht_array[w_dht_idx];
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DHT_BYTES - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SOS;
          end
        end
        S_SOS: begin
          w_out_valid = 1'b1;
          w_out_data  = sos_array[w_sos_idx];
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(SOS_BYTES - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SCAN;
          end
        end
        S_SCAN: begin
          if (s_valid) begin
            w_out_valid = 1'b1;
            w_out_data  = s_data;
            if (s_data == 8'hFF) begin
              // Remember whether the frame ends after the stuffed zero.
              w_pend_nxt  = s_last;
              w_state_nxt = S_STUFF;
            end else if (s_last) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_EOI;
            end
          end
        end
        S_STUFF: begin
          w_out_valid = 1'b1;
          w_out_data  = 8'h00;
          w_pend_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = r_pend_last ? S_EOI : S_SCAN;
        end
        S_EOI: begin
          if (r_cnt == CNT_W'(0)) begin
            w_out_valid = 1'b1;
            w_out_data  = 8'hFF;
            w_cnt_nxt   = CNT_W'(1);
          end else if (r_cnt == CNT_W'(1)) begin
            w_out_valid = 1'b1;
            w_out_data  = 8'hD9;
            w_out_last  = 1'b1;
            w_cnt_nxt   = CNT_W'(2);
          end else begin
            // The 0xD9 handshake is happening now: the frame is complete.
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pend_last <= 1'b0;
      // NOTE: the output data register is reset too, so m_data reads 0x00 after reset rather than X.
      r_m_data    <= 8'h00;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_last <= w_pend_nxt;
      r_done      <= w_done_nxt;
      if (w_adv) begin
        r_m_valid <= w_out_valid;
        r_m_last  <= w_out_last;
        if (w_out_valid) r_m_data <= w_out_data;
      end
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign done    = r_done;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Directed bench for jpeg_stream_sequencer: the whole frame is compared against a byte model,
// and stuffing, backpressure, reset abort and back-to-back starts are covered.
`timescale 1ns/1ps
module tb_jpeg_stream_sequencer;

  localparam int DQT_N   = 134;
  localparam int SOF_N   = 19;
  localparam int DHT_N   = 420;
  localparam int SOS_N   = 14;
  localparam int HDR_N   = 2 + DQT_N + SOF_N + DHT_N + SOS_N; // 589
  localparam int MAX_CYC = 6000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [DQT_N-1:0][7:0] dqt_array;
  logic [SOF_N-1:0][7:0] sof_array;
  logic [DHT_N-1:0][7:0] dht_array;
  logic [SOS_N-1:0][7:0] sos_array;
  logic [7:0]            s_data;
  logic                  s_valid, s_last, s_ready;
  logic [7:0]            m_data;
  logic                  m_valid, m_last, m_ready;
  logic                  busy, done;

  int total = 0;
  int bad   = 0;

  logic [7:0] hdr[$];
  logic [7:0] scan[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  logic       got_last[$];

  always #5 clk = ~clk;

  jpeg_stream_sequencer #(
    .DQT_BYTES(DQT_N), .SOF_BYTES(SOF_N), .DHT_BYTES(DHT_N), .SOS_BYTES(SOS_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dqt_array(dqt_array), .sof_array(sof_array), .dht_array(dht_array), .sos_array(sos_array),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  // Record each byte whose handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got.push_back(m_data);
      got_last.push_back(m_last);
    end
  end

  function automatic logic [7:0] seg_byte(input int seg, input int k);
    logic [7:0] pre [4];
    case (seg)
      0:       pre = '{8'hFF, 8'hDB, 8'h00, 8'h84};
      1:       pre = '{8'hFF, 8'hC0, 8'h00, 8'h11};
      2:       pre = '{8'hFF, 8'hC4, 8'h01, 8'hA2};
      default: pre = '{8'hFF, 8'hDA, 8'h00, 8'h0C};
    endcase
    if (k < 4) return pre[k];
    return 8'(k * (seg + 3) + seg);
  endfunction

  task automatic build_headers();
    hdr.delete();
    for (int k = 0; k < DQT_N; k++) begin dqt_array[DQT_N-1-k] = seg_byte(0, k); hdr.push_back(seg_byte(0, k)); end
    for (int k = 0; k < SOF_N; k++) begin sof_array[SOF_N-1-k] = seg_byte(1, k); hdr.push_back(seg_byte(1, k)); end
    for (int k = 0; k < DHT_N; k++) begin dht_array[DHT_N-1-k] = seg_byte(2, k); hdr.push_back(seg_byte(2, k)); end
    for (int k = 0; k < SOS_N; k++) begin sos_array[SOS_N-1-k] = seg_byte(3, k); hdr.push_back(seg_byte(3, k)); end
  endtask

  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD8);
    foreach (hdr[i]) exp_q.push_back(hdr[i]);
    foreach (scan[i]) begin
      exp_q.push_back(scan[i]);
      if (scan[i] == 8'hFF) exp_q.push_back(8'h00);
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
  endtask

  function automatic int first_diff();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic drive_inputs(input int si, input bit rnd);
    m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (si < scan.size()) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = scan[si];
      s_last  = (si == scan.size() - 1);
    end else begin
      s_valid = 1'b0;
      s_data  = 8'h00;
      s_last  = 1'b0;
    end
  endtask

  // Runs one frame. It returns at the falling edge where done is observed high.
  task automatic run_frame(input string name, input bit do_start, input bit rnd, input bit poke_start,
                           output int cyc);
    int si, d, nlast;
    bit acc, acc_ff, stall, done_seen;
    logic [7:0] pd;
    logic pl;
    si = 0; cyc = 0; acc = 0; acc_ff = 0; stall = 0; done_seen = 0; pd = 8'h00; pl = 1'b0;
    m_ready = 1'b1;
    build_exp();
    if (do_start) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    got.delete();
    got_last.delete();
    drive_inputs(si, rnd);
    @(negedge clk);
    total++;
    if ({m_valid, busy, m_data} !== {1'b1, 1'b1, 8'hFF})
      $display("FAIL %s_first_byte: valid=%0b busy=%0b data=%02h, want valid=1 busy=1 data=ff",
               name, m_valid, busy, m_data);
    while (cyc < MAX_CYC) begin
      if (done) begin done_seen = 1; break; end
      if (stall) begin
        total++;
        if ({m_valid, m_last, m_data} !== {1'b1, pl, pd}) begin
          bad++;
          $display("FAIL %s_stall_hold cyc=%0d: valid=%0b last=%0b data=%02h, want valid=1 last=%0b data=%02h",
                   name, cyc, m_valid, m_last, m_data, pl, pd);
        end
      end
      if (acc_ff) begin
        total++;
        if (s_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s_sready_after_ff cyc=%0d: s_ready=%0b, want 0", name, cyc, s_ready);
        end
      end
      acc    = s_valid && s_ready;
      acc_ff = acc && (s_data == 8'hFF);
      stall  = m_valid && !m_ready;
      pd     = m_data;
      pl     = m_last;
      @(posedge clk); #1;
      cyc++;
      if (acc) si++;
      start = poke_start && (cyc == 40 || cyc == 300);
      drive_inputs(si, rnd);
      @(negedge clk);
    end
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    total++;
    if (!done_seen) begin
      bad++;
      $display("FAIL %s_timeout: no done within %0d cycles, got %0d bytes", name, MAX_CYC, got.size());
    end
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_length: got %0d bytes, want %0d", name, got.size(), exp_q.size());
    end
    d = first_diff();
    total++;
    if (d >= 0) begin
      bad++;
      $display("FAIL %s_bytes: first difference at byte %0d: got %02h, want %02h", name, d, got[d], exp_q[d]);
    end
    nlast = 0;
    foreach (got_last[i]) if (got_last[i] === 1'b1) nlast++;
    total++;
    if (nlast != 1 || got_last.size() == 0 || got_last[got_last.size()-1] !== 1'b1) begin
      bad++;
      $display("FAIL %s_m_last: %0d bytes flagged last (final flag %0b), want exactly the final byte",
               name, nlast, (got_last.size() > 0) ? got_last[got_last.size()-1] : 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({m_valid, m_last, busy, done, s_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: valid=%0b last=%0b busy=%0b done=%0b s_ready=%0b, want all 0",
               m_valid, m_last, busy, done, s_ready);
    end
    total++;
    if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data: m_data=%02h, want 00", m_data); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({m_valid, busy, done, s_ready} !== 4'b0) begin
      bad++;
      $display("FAIL idle_after_reset: valid=%0b busy=%0b done=%0b s_ready=%0b, want all 0",
               m_valid, busy, done, s_ready);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, n;
    scan = '{8'h12, 8'h34};
    run_frame("basic", 1, 0, 0, cyc);
    n = got.size();
    total++;
    if (cyc != HDR_N + 2 + 2) begin bad++; $display("FAIL basic_no_bubbles: %0d cycles, want %0d", cyc, HDR_N + 4); end
    total++;
    if ({got[2], got[3], got[4], got[5]} !== 32'hFFDB0084) begin
      bad++;
      $display("FAIL basic_dqt_head: got %02h %02h %02h %02h, want ff db 00 84", got[2], got[3], got[4], got[5]);
    end
    total++;
    if (got[HDR_N] !== 8'h12) begin bad++; $display("FAIL basic_hdr_latency: byte %0d = %02h, want 12", HDR_N, got[HDR_N]); end
    total++;
    if ({got[n-4], got[n-3], got[n-2], got[n-1]} !== 32'h1234FFD9) begin
      bad++;
      $display("FAIL basic_tail: got %02h %02h %02h %02h, want 12 34 ff d9", got[n-4], got[n-3], got[n-2], got[n-1]);
    end
    @(posedge clk); #1;
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL basic_done_pulse: done=%0b busy=%0b, want 0 0", done, busy); end
  endtask

  task automatic test_stuffing();
    int cyc, n;
    scan = '{8'h12, 8'hFF, 8'h34};
    run_frame("stuff", 1, 0, 0, cyc);
    n = got.size();
    total++;
    if ({got[n-6], got[n-5], got[n-4], got[n-3], got[n-2], got[n-1]} !== 48'h12FF0034FFD9) begin
      bad++;
      $display("FAIL stuff_tail: got %02h %02h %02h %02h %02h %02h, want 12 ff 00 34 ff d9",
               got[n-6], got[n-5], got[n-4], got[n-3], got[n-2], got[n-1]);
    end
    total++;
    if (cyc != HDR_N + 4 + 2) begin bad++; $display("FAIL stuff_no_bubbles: %0d cycles, want %0d", cyc, HDR_N + 6); end
  endtask

  task automatic test_last_ff();
    int cyc, n;
    scan = '{8'hFF};
    run_frame("last_ff", 1, 0, 0, cyc);
    n = got.size();
    total++;
    if ({got[n-4], got[n-3], got[n-2], got[n-1]} !== 32'hFF00FFD9) begin
      bad++;
      $display("FAIL last_ff_tail: got %02h %02h %02h %02h, want ff 00 ff d9", got[n-4], got[n-3], got[n-2], got[n-1]);
    end
  endtask

  task automatic test_random();
    int cyc;
    scan = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h7E, 8'hFF};
    run_frame("random", 1, 1, 0, cyc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    m_ready = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    total++;
    if ({busy, m_valid} !== 2'b11) begin bad++; $display("FAIL mid_dht_busy: busy=%0b valid=%0b, want 1 1", busy, m_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_valid, m_last, busy, done, s_ready, m_data} !== 13'b0) begin
      bad++;
      $display("FAIL reset_abort: valid=%0b last=%0b busy=%0b done=%0b s_ready=%0b data=%02h, want all 0",
               m_valid, m_last, busy, done, s_ready, m_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    scan = '{8'h55, 8'h66};
    run_frame("after_reset", 1, 0, 0, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    scan = '{8'h99};
    run_frame("start_while_busy", 1, 0, 1, cyc);
    total++;
    if (cyc != HDR_N + 1 + 2) begin bad++; $display("FAIL busy_start_ignored: %0d cycles, want %0d", cyc, HDR_N + 3); end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    scan = '{8'hC3, 8'h3C};
    run_frame("back_to_back", 0, 0, 0, cyc);
  endtask

  initial begin
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    build_headers();
    test_reset();
    test_basic();
    test_stuffing();
    test_last_ff();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
